// File: rtl/ts_pkg.sv
// Shared MPEG-2 transport stream constants and the aligner state encoding.
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_sync_aligner.sv
// TS packet aligner: hunts for the sync byte, verifies it repeats every
// PKT_LEN bytes, then forwards framed packets and keeps QoS statistics.
//
// Stream handshake: in_valid qualifies in_data for exactly one rclk cycle
// and there is no ready; every valid beat is consumed. out_valid likewise
// qualifies out_data/out_sop/out_eop/out_sync_err for one cycle, and the
// downstream consumer must take every beat.
module ts_sync_aligner
  import ts_pkg::*;
#(
  parameter int         PKT_LEN      = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE    = TS_SYNC_BYTE,
  parameter int         LOCK_COUNT   = 3,
  parameter int         UNLOCK_COUNT = 3,
  parameter int         CNT_WIDTH    = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 enable,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 out_sync_err,
  output logic                 locked,
  output logic                 sync_lost,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [1:0]           dbg_state
);

  localparam int BCW = $clog2(PKT_LEN);
  localparam int GCW = $clog2(LOCK_COUNT + 1);
  localparam int MCW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [BCW-1:0] LAST_POS = BCW'(PKT_LEN - 1);

  ts_state_e      state, state_n;
  logic [BCW-1:0] byte_cnt, byte_n, byte_inc;
  logic [GCW-1:0] good_cnt, good_n, good_inc;
  logic [MCW-1:0] miss_cnt, miss_n, miss_inc;
  logic           fwd, sop_n, eop_n, serr_n, lost_n, err_inc;
  logic           is_sync, at_pos0;

  assign byte_inc = (byte_cnt == LAST_POS) ? '0 : byte_cnt + BCW'(1);
  assign good_inc = good_cnt + GCW'(1);
  assign miss_inc = miss_cnt + MCW'(1);
  assign is_sync  = (in_data == SYNC_BYTE);
  assign at_pos0  = (byte_cnt == '0);

  // Next-state and per-beat framing decisions; enable low overrides everything.
  always_comb begin
    state_n = state;
    byte_n  = byte_cnt;
    good_n  = good_cnt;
    miss_n  = miss_cnt;
    fwd     = 1'b0;
    sop_n   = 1'b0;
    eop_n   = 1'b0;
    serr_n  = 1'b0;
    lost_n  = 1'b0;
    err_inc = 1'b0;
    if (!enable) begin
      state_n = ST_HUNT;
      byte_n  = '0;
      good_n  = '0;
      miss_n  = '0;
      lost_n  = (state == ST_LOCKED);
    end else if (in_valid) begin
      case (state)
        ST_HUNT: begin
          if (is_sync) begin
            state_n = ST_VERIFY;
            byte_n  = BCW'(1);
            good_n  = GCW'(1);
          end
        end
        ST_VERIFY: begin
          byte_n = byte_inc;
          if (at_pos0) begin
            if (is_sync) begin
              good_n = good_inc;
              if (good_inc == GCW'(LOCK_COUNT)) begin
                state_n = ST_LOCKED;
                miss_n  = '0;
                fwd     = 1'b1;
                sop_n   = 1'b1;
              end
            end else begin
              // The mismatching byte is consumed; hunting restarts on the next one.
              state_n = ST_HUNT;
              byte_n  = '0;
              good_n  = '0;
            end
          end
        end
        ST_LOCKED: begin
          byte_n = byte_inc;
          fwd    = 1'b1;
          eop_n  = (byte_cnt == LAST_POS);
          if (at_pos0) begin
            sop_n = 1'b1;
            if (is_sync) begin
              miss_n = '0;
            end else begin
              err_inc = 1'b1;
              miss_n  = miss_inc;
              serr_n  = 1'b1;
              if (miss_inc == MCW'(UNLOCK_COUNT)) begin
                // Lock lost: the bad sync byte is not forwarded.
                state_n = ST_HUNT;
                byte_n  = '0;
                good_n  = '0;
                miss_n  = '0;
                fwd     = 1'b0;
                sop_n   = 1'b0;
                serr_n  = 1'b0;
                lost_n  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_n = ST_HUNT;
          byte_n  = '0;
          good_n  = '0;
          miss_n  = '0;
        end
      endcase
    end
  end

  // State, position counters and registered outputs.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state        <= ST_HUNT;
      byte_cnt     <= '0;
      good_cnt     <= '0;
      miss_cnt     <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_sync_err <= 1'b0;
      sync_lost    <= 1'b0;
      pkt_cnt      <= '0;
      err_cnt      <= '0;
    end else begin
      state        <= state_n;
      byte_cnt     <= byte_n;
      good_cnt     <= good_n;
      miss_cnt     <= miss_n;
      out_valid    <= fwd;
      out_sop      <= fwd & sop_n;
      out_eop      <= fwd & eop_n;
      out_sync_err <= fwd & serr_n;
      sync_lost    <= lost_n;
      if (fwd) begin
        out_data <= in_data;
      end
      if (fwd && eop_n) begin
        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
      if (err_inc && (err_cnt != {CNT_WIDTH{1'b1}})) begin
        err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign locked    = (state == ST_LOCKED);
  assign dbg_state = state;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Directed bench for ts_sync_aligner: acquisition, false-sync rejection,
// sync-error handling, loss/relock, gapped input, enable drop and reset.
module tb_ts_sync_aligner;
  import ts_pkg::*;

  logic        rclk;
  logic        rrst_n;
  logic        enable;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        out_sync_err;
  logic        locked;
  logic        sync_lost;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int vcnt, sopc, eopc, gidle;

  ts_sync_aligner dut (
    .rclk(rclk), .rrst_n(rrst_n), .enable(enable),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_sync_err(out_sync_err), .locked(locked),
    .sync_lost(sync_lost), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Payload never equals the sync byte so only real sync positions can match.
  function automatic logic [7:0] pay(input int p, input int i);
    logic [7:0] v;
    v = 8'(i * 3 + p * 5 + 1);
    if (v == 8'h47) v = 8'h48;
    return v;
  endfunction

  function automatic logic [7:0] pb(input int p, input int i);
    return (i == 0) ? 8'h47 : pay(p, i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 ns after the edge.
  task automatic step(input logic [7:0] d, input logic v);
    in_data  = d;
    in_valid = v;
    @(posedge rclk);
    #1;
    if (out_valid) vcnt++;
    if (out_valid && out_sop) sopc++;
    if (out_valid && out_eop) eopc++;
  endtask

  task automatic send_bytes(input int p, input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) begin
      step(pb(p, i), 1'b1);
      if (gap) begin
        step(8'h47, 1'b0);
        if (out_valid || out_sop || out_eop || out_sync_err) gidle++;
      end
    end
  endtask

  initial begin
    rrst_n = 1'b0; enable = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    vcnt = 0; sopc = 0; eopc = 0; gidle = 0;
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    check("rst_outs", {out_valid, out_sop, out_eop, out_sync_err, locked, sync_lost}, 6'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_cnts", {pkt_cnt, err_cnt}, 32'h0);
    check("rst_state", dbg_state, ST_HUNT);
    rrst_n = 1'b1; enable = 1'b1;

    // Clean aligned stream of 6 packets
    for (int b = 0; b < 6 * 188; b++) begin
      step(pb(b / 188, b % 188), 1'b1);
      if (b == 375) begin
        check("clean_prelock_locked", locked, 1'b0);
        check("clean_prelock_vcnt", vcnt, 0);
      end
      if (b == 376) begin
        check("clean_lock_locked", locked, 1'b1);
        check("clean_lock_frame", {out_valid, out_sop, out_eop, out_sync_err}, 4'b1100);
        check("clean_lock_data", out_data, 8'h47);
      end
      if (b == 563) begin
        check("clean_eop_frame", {out_valid, out_sop, out_eop}, 3'b101);
        check("clean_eop_data", out_data, pay(2, 187));
      end
    end
    check("clean_pkt_cnt", pkt_cnt, 4);
    check("clean_sop_eop", {sopc[15:0], eopc[15:0]}, {16'd4, 16'd4});
    check("clean_vcnt", vcnt, 4 * 188);
    step(8'h47, 1'b0);
    check("idle_no_valid", {out_valid, out_sop, out_eop}, 3'b000);

    // Single corrupted sync while locked
    step(8'h00, 1'b1);
    check("bad1_frame", {out_valid, out_sop, out_sync_err}, 3'b111);
    check("bad1_data", out_data, 8'h00);
    check("bad1_err_cnt", err_cnt, 1);
    check("bad1_locked", locked, 1'b1);
    send_bytes(6, 1, 187, 1'b0);
    step(8'h47, 1'b1);
    check("good_after_bad_frame", {out_valid, out_sop, out_sync_err}, 3'b110);
    send_bytes(7, 1, 187, 1'b0);
    check("t2_pkt_cnt", pkt_cnt, 6);
    check("t2_err_cnt", err_cnt, 1);

    // Asynchronous reset mid-packet
    send_bytes(8, 0, 49, 1'b0);
    #2;
    rrst_n = 1'b0;
    #1;
    check("midrst_outs", {out_valid, out_sop, out_eop, out_sync_err, locked, sync_lost}, 6'b0);
    check("midrst_cnts", {pkt_cnt, err_cnt}, 32'h0);
    check("midrst_state", dbg_state, ST_HUNT);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;

    // Garbage with a false sync at offset 10, then aligned packets from offset 50
    vcnt = 0;
    for (int k = 0; k < 50; k++) begin
      step((k == 10) ? 8'h47 : 8'(k + 16), 1'b1);
      if (k == 10) check("garb_false_verify", dbg_state, ST_VERIFY);
    end
    for (int o = 50; o < 50 + 4 * 188; o++) begin
      step(pb(10 + (o - 50) / 188, (o - 50) % 188), 1'b1);
      if (o == 197) check("garb_still_verify", dbg_state, ST_VERIFY);
      if (o == 198) check("garb_verify_fail", dbg_state, ST_HUNT);
      if (o == 238) check("garb_true_verify", dbg_state, ST_VERIFY);
      if (o == 613) begin
        check("garb_prelock_vcnt", vcnt, 0);
        check("garb_prelock_locked", locked, 1'b0);
      end
      if (o == 614) begin
        check("garb_lock_frame", {locked, out_valid, out_sop}, 3'b111);
        check("garb_lock_data", out_data, 8'h47);
      end
    end
    check("garb_pkt_cnt", pkt_cnt, 1);

    // Three consecutive corrupted syncs drop lock
    step(8'h00, 1'b1);
    check("miss1_frame", {out_valid, out_sop, out_sync_err, locked}, 4'b1111);
    check("miss1_err_cnt", err_cnt, 1);
    send_bytes(14, 1, 187, 1'b0);
    step(8'h00, 1'b1);
    check("miss2_frame", {out_valid, out_sop, out_sync_err, locked}, 4'b1111);
    check("miss2_err_cnt", err_cnt, 2);
    send_bytes(15, 1, 187, 1'b0);
    step(8'h00, 1'b1);
    check("miss3_frame", {out_valid, sync_lost, locked}, 3'b010);
    check("miss3_err_cnt", err_cnt, 3);
    step(pay(16, 1), 1'b1);
    check("miss3_lost_pulse", sync_lost, 1'b0);
    send_bytes(16, 2, 187, 1'b0);
    check("miss3_pkt_cnt", pkt_cnt, 3);
    send_bytes(17, 0, 187, 1'b0);
    send_bytes(18, 0, 187, 1'b0);
    check("relock_pre", locked, 1'b0);
    step(8'h47, 1'b1);
    check("relock_frame", {locked, out_valid, out_sop}, 3'b111);
    send_bytes(19, 1, 187, 1'b0);
    check("relock_pkt_cnt", pkt_cnt, 4);

    // Gapped input: framing must survive idle cycles
    sopc = 0; eopc = 0; gidle = 0;
    send_bytes(20, 0, 187, 1'b1);
    check("gap_pkt_cnt", pkt_cnt, 5);
    check("gap_sop_eop", {sopc[15:0], eopc[15:0]}, {16'd1, 16'd1});
    check("gap_idle_quiet", gidle, 0);

    // Enable dropped at byte 100 of a locked packet (byte is dropped)
    eopc = 0;
    send_bytes(21, 0, 99, 1'b1);
    check("drop_pre_locked", locked, 1'b1);
    enable = 1'b0;
    step(pay(21, 100), 1'b1);
    check("drop_frame", {out_valid, sync_lost, locked}, 3'b010);
    check("drop_state", dbg_state, ST_HUNT);
    enable = 1'b1;
    step(8'h00, 1'b0);
    check("drop_lost_pulse", sync_lost, 1'b0);
    send_bytes(21, 101, 187, 1'b1);
    check("drop_no_eop", eopc, 0);
    check("drop_pkt_cnt", pkt_cnt, 5);
    send_bytes(22, 0, 187, 1'b1);
    send_bytes(23, 0, 187, 1'b1);
    step(8'h47, 1'b1);
    check("drop_relock", {locked, out_valid, out_sop, out_sync_err}, 4'b1110);
    send_bytes(24, 1, 187, 1'b1);
    check("final_pkt_cnt", pkt_cnt, 6);
    check("final_err_cnt", err_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ts_sync_aligner.md
Name: ts_sync_aligner

Overview:
- Read-domain consumer of the rclk-side byte stream delivered by the TS CDC FIFO controller (100 MHz, valid-qualified, no backpressure).
- Acquires and tracks MPEG-2 TS packet alignment by hunting for the 0x47 sync byte every PKT_LEN bytes.
- Once locked, forwards aligned packets with start/end framing, flags corrupted sync bytes and keeps packet/error statistics for QoS.

Parameters:
PKT_LEN, 188, bytes per TS packet
SYNC_BYTE, 8'h47, sync byte value
LOCK_COUNT, 3, consecutive good sync bytes required to lock (>=2)
UNLOCK_COUNT, 3, consecutive bad sync bytes while locked that drop lock (>=1)
CNT_WIDTH, 16, width of statistics counters

Ports:
rclk  in  1  read-domain clock, 100 MHz
rrst_n  in  1  reset, asynchronous, active-low
enable  in  1  aligner enable; low forces HUNT
in_data  in  8  byte from FIFO read side
in_valid  in  1  in_data valid this cycle
out_data  out  8  forwarded byte
out_valid  out  1  out_data valid
out_sop  out  1  first byte of packet (with out_valid)
out_eop  out  1  last byte of packet (with out_valid)
out_sync_err  out  1  with out_sop: the packet's sync byte != SYNC_BYTE
locked  out  1  state == LOCKED
sync_lost  out  1  one-cycle pulse on LOCKED->HUNT
pkt_cnt  out  CNT_WIDTH  packets forwarded (eop count), wraps
err_cnt  out  CNT_WIDTH  sync errors while locked, saturates at all-ones

Behaviour:
- Reset: all outputs 0, state HUNT, byte/good/miss counters 0.
- All logic advances only on cycles where in_valid=1; idle cycles hold state and drive out_valid/out_sop/out_eop/out_sync_err/sync_lost to 0.
- Latency: all outputs registered; an accepted byte appears on out_data exactly 1 cycle after its in_valid beat.
- byte_cnt: position within the packet, 0..PKT_LEN-1, width clog2(PKT_LEN). Wraps PKT_LEN-1 -> 0.
- HUNT:
  - in_data==SYNC_BYTE -> VERIFY, byte_cnt=1, good_cnt=1.
  - Otherwise stay.
  - No output.
- VERIFY:
  - byte_cnt increments.
  - At the position-0 byte (byte_cnt wrapped to 0), if in_data==SYNC_BYTE: good_cnt++.
    - If good_cnt reaches LOCK_COUNT -> LOCKED, and this byte is forwarded as out_sop.
    - Otherwise stay in VERIFY.
  - At the position-0 byte, if in_data!=SYNC_BYTE -> HUNT. The byte is consumed; hunting resumes on the next byte.
  - No output while in VERIFY.
- LOCKED:
  - Every byte is forwarded. out_sop on position 0, out_eop on position PKT_LEN-1.
  - Position 0 == SYNC_BYTE: miss_cnt=0.
  - Position 0 != SYNC_BYTE: miss_cnt++ and err_cnt++ (saturating).
    - If miss_cnt reaches UNLOCK_COUNT -> HUNT: this byte is NOT forwarded, sync_lost pulses, locked falls next cycle.
    - Otherwise the byte is forwarded with out_sop=1 and out_sync_err=1.
- pkt_cnt increments on each forwarded out_eop beat; wraps modulo 2^CNT_WIDTH.
- enable=0 (any state, any cycle): next state HUNT, counters byte/good/miss cleared, no output. If previously LOCKED, sync_lost pulses once. A packet in flight is truncated (sop without eop); downstream must tolerate this. Statistics are kept.
- Simultaneous enable fall and in_valid: enable wins; the byte is dropped.
- rrst_n asserted mid-packet: immediate return to reset values including statistics.
- PKT_LEN=204 (RS-coded TS) must work by parameter change only.

Decomposition:
- Shared package ts_pkg: TS_SYNC_BYTE (8'h47), TS_PKT_LEN (188), state encoding HUNT/VERIFY/LOCKED.
- No sub-module required. The saturating err_cnt is inline logic.

Test Plan:
- Reset: assert rrst_n low mid-stream -> all outputs 0, locked=0, pkt_cnt=err_cnt=0 immediately.
- Clean stream of 6 aligned packets, continuous in_valid:
  - locked rises 1 cycle after input byte 376.
  - out_sop with out_data=8'h47 at that cycle; out_eop 187 cycles later.
  - pkt_cnt=4 after the stream ends.
- 50 garbage bytes containing 0x47 at offset 10, then aligned packets:
  - VERIFY fails at offset 198 and returns to HUNT.
  - Lock is acquired on the true alignment; no out_valid before lock.
- Locked, sync byte of packet 5 replaced by 8'h00:
  - That packet is forwarded with out_sop=1 and out_sync_err=1.
  - err_cnt=1, locked stays 1, miss count resets on packet 6.
- Locked, 3 consecutive corrupted sync bytes:
  - First two forwarded with out_sync_err.
  - On the third: no out_valid, sync_lost pulses one cycle, locked=0, err_cnt=3.
  - Relocks after 3 clean syncs.
- in_valid asserted every other cycle, then enable dropped at byte 100 of a locked packet:
  - Framing is correct under gaps.
  - On the drop: sync_lost pulses, no out_eop for the truncated packet.
  - After enable returns, lock is reacquired.
